register_file: RTL and testbench

//  32 x 32-bit integer register file answering instruction_decode's rs1/rs2 reads and accepting the rd write-back.
//  Two combinational read ports and one synchronous core write port; x0 is hardwired to zero.

---
 rtl/register_file.sv | 168 ++++++++++++++++
 tb/tb_register_file.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x 32-bit register file: two combinational read ports, one core write port and a four-phase debug port.
// Optional macro WRITE_BYPASS_EN forwards same-cycle core write data to the read ports.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rd_wen_i,
    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
    input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
    output logic [DATA_WIDTH-1:0] dbg_rdata_o,
    output logic                  dbg_ack_o
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } dbg_state_e;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    dbg_state_e            state_q;
    logic                  dbg_we_q;
    logic [ADDR_WIDTH-1:0] dbg_addr_q;
    logic [DATA_WIDTH-1:0] dbg_wdata_q;
    logic [DATA_WIDTH-1:0] dbg_rdata_q;
    logic                  dbg_ack_q;
    logic [DATA_WIDTH-1:0] dbg_rdata_d;

    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic                  core_wr_s;

    assign core_wr_s = rd_wen_i && (rd_addr_i != '0);

    // Read port 1: x0 reads zero, optional forwarding of the in-flight core write
    always_comb begin
        rs1_data_o = '0;
        if (rs1_addr_i != '0) begin
            rs1_data_o = regs_q[rs1_addr_i];
        end else begin
            rs1_data_o = '0;
        end
`ifdef WRITE_BYPASS_EN
        if (core_wr_s && (rd_addr_i == rs1_addr_i)) begin
            rs1_data_o = rd_data_i;
        end else begin
            rs1_data_o = rs1_data_o;
        end
`endif
    end

    // Read port 2: same structure as port 1
    always_comb begin
        rs2_data_o = '0;
        if (rs2_addr_i != '0) begin
            rs2_data_o = regs_q[rs2_addr_i];
        end else begin
            rs2_data_o = '0;
        end
`ifdef WRITE_BYPASS_EN
        if (core_wr_s && (rd_addr_i == rs2_addr_i)) begin
            rs2_data_o = rd_data_i;
        end else begin
            rs2_data_o = rs2_data_o;
        end
`endif
    end

    // Debug read value sampled from the array before this edge's write lands
    always_comb begin
        dbg_rdata_d = '0;
        if (dbg_addr_q != '0) begin
            dbg_rdata_d = regs_q[dbg_addr_q];
        end else begin
            dbg_rdata_d = '0;
        end
    end

    // Single write port arbitration; a debug write only proceeds when the core is not writing at all
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = '0;
        if (core_wr_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = rd_addr_i;
            wr_data_s = rd_data_i;
        end else if ((state_q == ST_ACCESS) && dbg_we_q && !rd_wen_i && (dbg_addr_q != '0)) begin
            wr_en_s   = 1'b1;
            wr_addr_s = dbg_addr_q;
            wr_data_s = dbg_wdata_q;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Register array storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Debug handshake FSM with registered ack and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dbg_we_q    <= 1'b0;
            dbg_addr_q  <= '0;
            dbg_wdata_q <= '0;
            dbg_rdata_q <= '0;
            dbg_ack_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dbg_req_i) begin
                        dbg_we_q    <= dbg_we_i;
                        dbg_addr_q  <= dbg_addr_i;
                        dbg_wdata_q <= dbg_wdata_i;
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Deferred writes wait indefinitely; reads complete regardless of core traffic
                    if (!(dbg_we_q && rd_wen_i)) begin
                        if (!dbg_we_q) begin
                            dbg_rdata_q <= dbg_rdata_d;
                        end
                        dbg_ack_q <= 1'b1;
                        state_q   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!dbg_req_i) begin
                        dbg_ack_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    dbg_ack_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_rdata_o = dbg_rdata_q;
    assign dbg_ack_o   = dbg_ack_q;

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file plus hand-written debug-port sequences.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
    logic [31:0] rs1_data, rs2_data, rd_data, dbg_wdata, dbg_rdata;
    logic        rd_wen, dbg_req, dbg_we, dbg_ack;

    int checks   = 0;
    int failures = 0;

`ifdef WRITE_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    typedef struct {
        logic        wen;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [8];

    register_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_addr_i  (rs1_addr),
        .rs2_addr_i  (rs2_addr),
        .rs1_data_o  (rs1_data),
        .rs2_data_o  (rs2_data),
        .rd_addr_i   (rd_addr),
        .rd_data_i   (rd_data),
        .rd_wen_i    (rd_wen),
        .dbg_req_i   (dbg_req),
        .dbg_we_i    (dbg_we),
        .dbg_addr_i  (dbg_addr),
        .dbg_wdata_i (dbg_wdata),
        .dbg_rdata_o (dbg_rdata),
        .dbg_ack_o   (dbg_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0; rd_data = 32'h0;
        rd_wen = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'h0;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd7,  32'h00000011, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd7,  5'd0,  32'h00000011, 32'h0};
        vecs[4] = '{1'b0, 5'd4,  32'h55555555, 5'd31, 5'd4,  32'hFFFFFFFF, 32'h0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd4,  5'd31, 32'h0,        32'hFFFFFFFF};
        vecs[6] = '{1'b1, 5'd1,  32'h00000001, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd7,  32'h00000001, 32'h00000011};

        // Reset state
        tick(); tick();
        check("rst_ack", {31'd0, dbg_ack}, 32'h0);
        check("rst_rdata", dbg_rdata, 32'h0);
        rst_n = 1'b1;
        tick();
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i + 1);
            #1;
            check("rst_rs1", rs1_data, 32'h0);
            check("rst_rs2", rs2_data, 32'h0);
        end
        tick();

        // Table of core write/read vectors; expectations are pre-edge values
        for (int v = 0; v < 8; v++) begin
            rd_wen = vecs[v].wen; rd_addr = vecs[v].rd_addr; rd_data = vecs[v].rd_data;
            rs1_addr = vecs[v].rs1; rs2_addr = vecs[v].rs2;
            #2;
            check("vec_rs1", rs1_data, vecs[v].exp1);
            check("vec_rs2", rs2_data, vecs[v].exp2);
            tick();
        end

        // Same-cycle write/read of x7
        rd_wen = 1'b1; rd_addr = 5'd7; rd_data = 32'hA5A5A5A5; rs1_addr = 5'd7; rs2_addr = 5'd0;
        #2;
        check("same_cycle_rs1", rs1_data, BYPASS ? 32'hA5A5A5A5 : 32'h00000011);
        check("same_cycle_x0", rs2_data, 32'h0);
        tick();
        rd_wen = 1'b0;
        #2;
        check("after_write_rs1", rs1_data, 32'hA5A5A5A5);

        // Debug write deferred by three cycles of core writes
        rd_wen = 1'b1; rd_addr = 5'd2; rd_data = 32'h22222222;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hCAFEF00D;
        tick();
        check("dw_ack_e0", {31'd0, dbg_ack}, 32'h0);
        rd_addr = 5'd0;
        tick();
        check("dw_ack_e1", {31'd0, dbg_ack}, 32'h0);
        rd_addr = 5'd3;
        tick();
        check("dw_ack_e2", {31'd0, dbg_ack}, 32'h0);
        rd_wen = 1'b0;
        tick();
        check("dw_ack_e3", {31'd0, dbg_ack}, 32'h1);
        rs1_addr = 5'd9; rs2_addr = 5'd3;
        #1;
        check("dw_x9", rs1_data, 32'hCAFEF00D);
        check("dw_x3_core", rs2_data, 32'h22222222);
        tick();
        check("dw_ack_hold", {31'd0, dbg_ack}, 32'h1);
        dbg_req = 1'b0;
        tick();
        check("dw_ack_drop", {31'd0, dbg_ack}, 32'h0);

        // Debug read x5 with full handshake
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        tick();
        check("dr_ack_e0", {31'd0, dbg_ack}, 32'h0);
        tick();
        check("dr_ack_e1", {31'd0, dbg_ack}, 32'h1);
        check("dr_rdata", dbg_rdata, 32'hDEADBEEF);
        dbg_addr = 5'd7;
        tick(); tick();
        check("dr_ack_held", {31'd0, dbg_ack}, 32'h1);
        check("dr_no_reissue", dbg_rdata, 32'hDEADBEEF);
        dbg_req = 1'b0;
        tick();
        check("dr_ack_low", {31'd0, dbg_ack}, 32'h0);
        check("dr_rdata_hold", dbg_rdata, 32'hDEADBEEF);

        // Debug read of x7 with req dropped in ACCESS and a colliding core write
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
        tick();
        dbg_req = 1'b0; rd_wen = 1'b1; rd_addr = 5'd7; rd_data = 32'h77777777;
        tick();
        check("drop_ack_pulse", {31'd0, dbg_ack}, 32'h1);
        check("drop_prewrite", dbg_rdata, 32'hA5A5A5A5);
        rd_wen = 1'b0; rs1_addr = 5'd7;
        tick();
        check("drop_ack_end", {31'd0, dbg_ack}, 32'h0);
        check("drop_x7_new", rs1_data, 32'h77777777);

        // Reset while a debug write to x3 is deferred in ACCESS
        rd_wen = 1'b1; rd_addr = 5'd4; rd_data = 32'h44444444;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h33333333;
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        check("arst_ack", {31'd0, dbg_ack}, 32'h0);
        check("arst_rdata", dbg_rdata, 32'h0);
        rd_wen = 1'b0; dbg_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        rs1_addr = 5'd3; rs2_addr = 5'd7;
        #1;
        check("arst_x3", rs1_data, 32'h0);
        check("arst_x7", rs2_data, 32'h0);
        check("arst_idle_ack", {31'd0, dbg_ack}, 32'h0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        tick();
        check("arst_new_e0", {31'd0, dbg_ack}, 32'h0);
        tick();
        check("arst_new_e1", {31'd0, dbg_ack}, 32'h1);
        dbg_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
